// File: rtl/readout_receiver.sv
// Purpose: far end of the spectrogram readout link; deserializes RTC header + channel words.
// Latency: one cycle from the last bit of a field to the registered timestamp / word outputs.
// Backpressure: single output slot; a word completing while the slot is still full is dropped and flags overrun.
module readout_receiver #(
  parameter int RTC_WIDTH  = 30,
  parameter int DATA_WIDTH = 16,
  parameter int MAX_WORDS  = 200
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  serial_readout,
  input  logic                  selection_bit,
  input  logic                  bit_valid,
  input  logic                  sdata,
  output logic [RTC_WIDTH-1:0]  rtc_out,
  output logic                  rtc_valid,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  input  logic                  data_ready,
  output logic [7:0]            word_count,
  output logic                  frame_done,
  output logic                  frame_error,
  output logic                  overrun
);

  // The shift register holds one bit fewer than the widest field: the
  // incoming bit completes the field combinationally on its last cycle.
  localparam int SH_W  = (RTC_WIDTH > DATA_WIDTH) ? RTC_WIDTH : DATA_WIDTH;
  localparam int CNT_W = $clog2(SH_W + 1);

  localparam logic [CNT_W-1:0] RTC_LAST  = CNT_W'(RTC_WIDTH - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [7:0]       WC_MAX    = 8'(MAX_WORDS);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HEADER  = 2'd1,
    ST_DATA    = 2'd2,
    ST_DISCARD = 2'd3
  } state_t;

  state_t                r_state;
  logic [CNT_W-1:0]      r_bit_cnt;
  logic [SH_W-2:0]       r_shift;
  logic [RTC_WIDTH-1:0]  r_rtc;
  logic                  r_rtc_valid;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_data_valid;
  logic [7:0]            r_word_count;
  logic                  r_frame_done;
  logic                  r_frame_error;
  logic                  r_overrun;

  state_t                w_state_nxt;
  logic [CNT_W-1:0]      w_bit_cnt_nxt;
  logic [CNT_W-1:0]      w_hdr_base;
  logic [RTC_WIDTH-1:0]  w_rtc_nxt;
  logic                  w_rtc_valid_nxt;
  logic [DATA_WIDTH-1:0] w_data_nxt;
  logic                  w_data_valid_nxt;
  logic [7:0]            w_word_count_nxt;
  logic                  w_frame_done_nxt;
  logic                  w_frame_error_nxt;
  logic                  w_overrun_nxt;
  logic                  w_accept;
  logic [SH_W-1:0]       w_shift_in;

  // Payload bits are taken only inside the envelope and never while discarding.
  assign w_accept   = serial_readout & bit_valid & (r_state != ST_DISCARD);
  assign w_shift_in = {r_shift, sdata};

  // Next-state and next-output decode; every target defaults to hold / idle first.
  always_comb begin
    w_state_nxt       = r_state;
    w_bit_cnt_nxt     = r_bit_cnt;
    w_hdr_base        = r_bit_cnt;
    w_rtc_nxt         = r_rtc;
    w_rtc_valid_nxt   = 1'b0;
    w_data_nxt        = r_data;
    w_data_valid_nxt  = r_data_valid & ~data_ready;
    w_word_count_nxt  = r_word_count;
    w_frame_done_nxt  = 1'b0;
    w_frame_error_nxt = r_frame_error;
    w_overrun_nxt     = r_overrun;

    unique case (r_state)
      // IDLE and HEADER share the header-bit handling: the envelope's first
      // cycle may already carry header bit 1, counted from a cleared base.
      ST_IDLE, ST_HEADER: begin
        if ((r_state == ST_HEADER) && !serial_readout) begin
          w_state_nxt       = ST_IDLE;
          w_frame_done_nxt  = 1'b1;
          w_frame_error_nxt = 1'b1;
        end else if (serial_readout) begin
          if (r_state == ST_IDLE) begin
            w_state_nxt       = ST_HEADER;
            w_hdr_base        = '0;
            w_bit_cnt_nxt     = '0;
            w_word_count_nxt  = 8'd0;
            w_frame_error_nxt = 1'b0;
            w_overrun_nxt     = 1'b0;
          end
          if (bit_valid) begin
            if (selection_bit) begin
              w_frame_error_nxt = 1'b1;
              w_state_nxt       = ST_DISCARD;
            end else if (w_hdr_base == RTC_LAST) begin
              w_rtc_nxt       = w_shift_in[RTC_WIDTH-1:0];
              w_rtc_valid_nxt = 1'b1;
              w_bit_cnt_nxt   = '0;
              w_state_nxt     = ST_DATA;
            end else begin
              w_bit_cnt_nxt = w_hdr_base + CNT_ONE;
            end
          end
        end
      end

      ST_DATA: begin
        if (!serial_readout) begin
          w_state_nxt      = ST_IDLE;
          w_frame_done_nxt = 1'b1;
          if (r_bit_cnt != '0) begin
            w_frame_error_nxt = 1'b1;
          end
        end else if (bit_valid) begin
          if (!selection_bit) begin
            w_frame_error_nxt = 1'b1;
            w_state_nxt       = ST_DISCARD;
          end else if (r_bit_cnt == DATA_LAST) begin
            w_bit_cnt_nxt = '0;
            if (r_word_count == WC_MAX) begin
              w_frame_error_nxt = 1'b1;
              w_state_nxt       = ST_DISCARD;
            end else begin
              w_word_count_nxt = r_word_count + 8'd1;
              // The slot frees this cycle if empty or being handshaken.
              if (!r_data_valid || data_ready) begin
                w_data_nxt       = w_shift_in[DATA_WIDTH-1:0];
                w_data_valid_nxt = 1'b1;
              end else begin
                w_overrun_nxt = 1'b1;
              end
            end
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + CNT_ONE;
          end
        end
      end

      ST_DISCARD: begin
        if (!serial_readout) begin
          w_state_nxt      = ST_IDLE;
          w_frame_done_nxt = 1'b1;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_bit_cnt     <= '0;
      r_shift       <= '0;
      r_rtc         <= '0;
      r_rtc_valid   <= 1'b0;
      r_data        <= '0;
      r_data_valid  <= 1'b0;
      r_word_count  <= 8'd0;
      r_frame_done  <= 1'b0;
      r_frame_error <= 1'b0;
      r_overrun     <= 1'b0;
    end else begin
      r_bit_cnt     <= w_bit_cnt_nxt;
      if (w_accept) begin
        r_shift <= w_shift_in[SH_W-2:0];
      end
      r_rtc         <= w_rtc_nxt;
      r_rtc_valid   <= w_rtc_valid_nxt;
      r_data        <= w_data_nxt;
      r_data_valid  <= w_data_valid_nxt;
      r_word_count  <= w_word_count_nxt;
      r_frame_done  <= w_frame_done_nxt;
      r_frame_error <= w_frame_error_nxt;
      r_overrun     <= w_overrun_nxt;
    end
  end

  assign rtc_out     = r_rtc;
  assign rtc_valid   = r_rtc_valid;
  assign data_out    = r_data;
  assign data_valid  = r_data_valid;
  assign word_count  = r_word_count;
  assign frame_done  = r_frame_done;
  assign frame_error = r_frame_error;
  assign overrun     = r_overrun;

endmodule

// File: tb/tb_readout_receiver.sv
// Purpose: randomized + directed bench for readout_receiver against a frame-level reference.
// Latency: reference predicts the post-edge value of every output each cycle.
// Backpressure: data_ready driven constant-high, constant-low or random per cycle.
module tb_readout_receiver;
  localparam int RTC_W = 30;
  localparam int DAT_W = 16;
  localparam int MAXW  = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              serial_readout;
  logic              selection_bit;
  logic              bit_valid;
  logic              sdata;
  logic              data_ready;
  logic [RTC_W-1:0]  rtc_out;
  logic              rtc_valid;
  logic [DAT_W-1:0]  data_out;
  logic              data_valid;
  logic [7:0]        word_count;
  logic              frame_done;
  logic              frame_error;
  logic              overrun;

  int checks   = 0;
  int failures = 0;
  int ready_mode = 0;
  bit chk_en = 1'b0;
  int done_cnt = 0;

  logic [15:0] words [8];
  logic [15:0] hs_q  [$];
  logic [29:0] rtc_q [$];

  // Reference state: whether we are inside a frame, whether the rest of it
  // is being ignored, whether the header is done, and the field accumulator.
  bit          m_in_frame, m_dead, m_hdr_done;
  int          m_nb;
  logic [31:0] m_acc;
  logic [29:0] m_rtc;
  bit          m_rtc_v;
  logic [15:0] m_dout;
  bit          m_dv;
  int          m_wc;
  bit          m_done, m_err, m_ovr;

  logic [63:0] dut_vec;
  assign dut_vec = {5'd0, rtc_out, rtc_valid, data_out, data_valid, word_count,
                    frame_done, frame_error, overrun};

  always #5 clk = ~clk;

  readout_receiver #(
    .RTC_WIDTH (RTC_W),
    .DATA_WIDTH(DAT_W),
    .MAX_WORDS (MAXW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .serial_readout(serial_readout),
    .selection_bit (selection_bit),
    .bit_valid     (bit_valid),
    .sdata         (sdata),
    .rtc_out       (rtc_out),
    .rtc_valid     (rtc_valid),
    .data_out      (data_out),
    .data_valid    (data_valid),
    .data_ready    (data_ready),
    .word_count    (word_count),
    .frame_done    (frame_done),
    .frame_error   (frame_error),
    .overrun       (overrun)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Frame-level reference, evaluated on the inputs present at each rising edge.
  always @(posedge clk) begin : ref_model
    bit hs, load;
    hs      = m_dv && (data_ready === 1'b1);
    load    = 1'b0;
    m_rtc_v = 1'b0;
    m_done  = 1'b0;
    if (reset) begin
      m_in_frame = 0; m_dead = 0; m_hdr_done = 0; m_nb = 0; m_acc = '0;
      m_rtc = '0; m_dout = '0; m_dv = 0; m_wc = 0; m_err = 0; m_ovr = 0;
      hs = 0;
    end else begin
      if (!m_in_frame) begin
        if (serial_readout) begin
          m_in_frame = 1; m_dead = 0; m_hdr_done = 0; m_nb = 0; m_acc = '0;
          m_wc = 0; m_err = 0; m_ovr = 0;
        end
      end else if (!serial_readout) begin
        m_in_frame = 0;
        m_done     = 1;
        if (!m_dead && (!m_hdr_done || m_nb != 0)) m_err = 1;
      end
      if (m_in_frame && serial_readout && bit_valid && !m_dead) begin
        if (selection_bit != m_hdr_done) begin
          m_err = 1; m_dead = 1;
        end else begin
          m_acc = {m_acc[30:0], sdata};
          m_nb++;
          if (!m_hdr_done && m_nb == RTC_W) begin
            m_rtc = m_acc[29:0]; m_rtc_v = 1; m_hdr_done = 1; m_nb = 0; m_acc = '0;
          end else if (m_hdr_done && m_nb == DAT_W) begin
            m_nb = 0;
            if (m_wc == MAXW) begin
              m_err = 1; m_dead = 1;
            end else begin
              m_wc++;
              if (!m_dv || data_ready) begin m_dout = m_acc[15:0]; load = 1; end
              else m_ovr = 1;
            end
            m_acc = '0;
          end
        end
      end
    end
    if (load) m_dv = 1;
    else if (hs) m_dv = 0;
  end

  // Handshake capture happens on the edge where the transfer occurs.
  always @(posedge clk) begin
    if (reset === 1'b0 && data_valid === 1'b1 && data_ready === 1'b1) hs_q.push_back(data_out);
  end

  // Per-cycle comparison against the reference, on the falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check_eq("cycle", dut_vec, {5'd0, m_rtc, m_rtc_v, m_dout, m_dv, 8'(m_wc), m_done, m_err, m_ovr});
      if (frame_done === 1'b1) done_cnt++;
      if (rtc_valid === 1'b1) rtc_q.push_back(rtc_out);
    end
  end

  function automatic logic [15:0] hs_at(input int i);
    return (i < hs_q.size()) ? hs_q[i] : 16'hxxxx;
  endfunction

  function automatic logic [29:0] rtc_at(input int i);
    return (i < rtc_q.size()) ? rtc_q[i] : 30'hxxxxxxxx;
  endfunction

  task automatic tick();
    case (ready_mode)
      0:       data_ready = 1'b1;
      1:       data_ready = 1'b0;
      default: data_ready = 1'($urandom_range(0, 1));
    endcase
    @(posedge clk);
    #1;
  endtask

  task automatic gap_cycle(input logic sel);
    serial_readout = 1'b1; bit_valid = 1'b0; selection_bit = sel;
    sdata = 1'($urandom_range(0, 1));
    tick();
  endtask

  task automatic send_bits(input logic sel, input logic [31:0] val, input int width, input bit gaps);
    for (int i = width - 1; i >= 0; i--) begin
      if (gaps && $urandom_range(0, 1) == 1) gap_cycle(1'($urandom_range(0, 1)));
      serial_readout = 1'b1; bit_valid = 1'b1; selection_bit = sel; sdata = val[i];
      tick();
    end
  endtask

  task automatic end_frame();
    serial_readout = 1'b0;
    bit_valid      = 1'($urandom_range(0, 1));
    selection_bit  = 1'($urandom_range(0, 1));
    sdata          = 1'($urandom_range(0, 1));
    tick();
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      serial_readout = 1'b0; bit_valid = 1'b0;
      tick();
    end
  endtask

  task automatic send_frame(input logic [29:0] rtc, input int hdr_len, input int n, input bit gaps,
                            input int word_gap, input int trunc, input bit bad_sel);
    send_bits(1'b0, 32'(rtc) >> (RTC_W - hdr_len), hdr_len, gaps);
    if (hdr_len == RTC_W) begin
      for (int w = 0; w < n; w++) begin
        if (w > 0) repeat (word_gap) gap_cycle(1'b1);
        send_bits(1'b1, 32'(words[w]), DAT_W, gaps);
      end
      send_bits(1'b1, $urandom, trunc, gaps);
      if (bad_sel) begin
        send_bits(1'b0, $urandom, 1, 1'b0);
        send_bits(1'b1, $urandom, 5, gaps);
      end
    end
    end_frame();
  endtask

  task automatic clear_capture();
    hs_q.delete(); rtc_q.delete(); done_cnt = 0;
  endtask

  task automatic nominal_checks(input string p);
    check_eq({p, "_done"}, frame_done, 1);
    check_eq({p, "_err"}, frame_error, 0);
    check_eq({p, "_wc"}, word_count, 2);
    idle(3);
    check_eq({p, "_hs_n"}, hs_q.size(), 2);
    check_eq({p, "_w0"}, hs_at(0), 16'h1234);
    check_eq({p, "_w1"}, hs_at(1), 16'hBEEF);
    check_eq({p, "_rtc_n"}, rtc_q.size(), 1);
    check_eq({p, "_rtc"}, rtc_at(0), 30'h2ABCDEF1);
    check_eq({p, "_done_n"}, done_cnt, 1);
  endtask

  initial begin
    reset = 1'b1; serial_readout = 1'b0; selection_bit = 1'b0;
    bit_valid = 1'b0; sdata = 1'b0; data_ready = 1'b1;
    tick();
    tick();
    chk_en = 1'b1;
    check_eq("reset_outs", dut_vec, 64'd0);
    reset = 1'b0;
    idle(2);

    // Nominal frame, continuous bits.
    ready_mode = 0; clear_capture();
    words[0] = 16'h1234; words[1] = 16'hBEEF;
    send_frame(30'h2ABCDEF1, RTC_W, 2, 1'b0, 0, 0, 1'b0);
    nominal_checks("nom");

    // Same frame with bit_valid gaps and a 20-cycle gap between words.
    clear_capture();
    send_frame(30'h2ABCDEF1, RTC_W, 2, 1'b1, 20, 0, 1'b0);
    nominal_checks("gap");

    // Backpressure: three words, consumer stalled for the whole frame.
    ready_mode = 1; clear_capture();
    words[0] = 16'h1111; words[1] = 16'h2222; words[2] = 16'h3333;
    send_frame(30'($urandom), RTC_W, 3, 1'b0, 0, 0, 1'b0);
    check_eq("bp_dout", data_out, 16'h1111);
    check_eq("bp_dv", data_valid, 1);
    check_eq("bp_ovr", overrun, 1);
    check_eq("bp_wc", word_count, 3);
    ready_mode = 0;
    tick();
    tick();
    check_eq("bp_hs_n", hs_q.size(), 1);
    check_eq("bp_hs_w", hs_at(0), 16'h1111);
    check_eq("bp_dv_drop", data_valid, 0);

    // Truncated second word, then a clean frame clears the error.
    clear_capture();
    words[0] = 16'hA5C3; words[1] = 16'h0F0F;
    send_frame(30'($urandom), RTC_W, 1, 1'b0, 0, 10, 1'b0);
    check_eq("trunc_done", frame_done, 1);
    check_eq("trunc_err", frame_error, 1);
    check_eq("trunc_wc", word_count, 1);
    idle(1);
    send_frame(30'($urandom), RTC_W, 2, 1'b0, 0, 0, 1'b0);
    check_eq("clean_err", frame_error, 0);
    check_eq("clean_wc", word_count, 2);

    // Overflow: one word beyond the bank limit.
    idle(2); clear_capture();
    for (int w = 0; w < 5; w++) words[w] = 16'($urandom);
    send_frame(30'($urandom), RTC_W, 5, 1'b0, 0, 0, 1'b0);
    check_eq("ovf_err", frame_error, 1);
    check_eq("ovf_wc", word_count, MAXW);
    idle(2);
    check_eq("ovf_hs_n", hs_q.size(), MAXW);
    check_eq("ovf_last", hs_at(MAXW - 1), words[MAXW - 1]);

    // Header-type bit inside the data phase.
    send_frame(30'($urandom), RTC_W, 1, 1'b0, 0, 0, 1'b1);
    check_eq("hdr_in_data_err", frame_error, 1);
    check_eq("hdr_in_data_wc", word_count, 1);

    // Reset after 15 header bits, then a fresh frame.
    idle(2);
    send_bits(1'b0, 32'h2ABCDEF1 >> 15, 15, 1'b0);
    reset = 1'b1; serial_readout = 1'b0; bit_valid = 1'b0;
    tick();
    check_eq("midrst_outs", dut_vec, 64'd0);
    reset = 1'b0;
    idle(1);
    clear_capture();
    words[0] = 16'h1234; words[1] = 16'hBEEF;
    send_frame(30'h2ABCDEF1, RTC_W, 2, 1'b0, 0, 0, 1'b0);
    nominal_checks("postrst");

    // Randomized frames, including back-to-back starts and malformed frames.
    for (int f = 0; f < 60; f++) begin
      int n, hl, tr;
      bit bs, gp;
      ready_mode = $urandom_range(0, 2);
      for (int w = 0; w < 8; w++) words[w] = 16'($urandom);
      n  = $urandom_range(0, 5);
      hl = ($urandom_range(0, 9) == 0) ? $urandom_range(1, RTC_W - 1) : RTC_W;
      tr = ($urandom_range(0, 5) == 0) ? $urandom_range(1, DAT_W - 1) : 0;
      bs = ($urandom_range(0, 7) == 0);
      gp = 1'($urandom_range(0, 1));
      send_frame(30'($urandom), hl, n, gp, $urandom_range(0, 3), tr, bs);
      idle($urandom_range(0, 2));
    end

    ready_mode = 0;
    idle(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
